// File: rtl/fmap_frame_sequencer_pkg.sv
// Shared constants and types for the fmap frame sequencer.
// Holds the feeder and CNN constants (frame size, class encoding, image
// count) plus the sequencer's timing constants and state encoding.
package fmap_frame_sequencer_pkg;

    localparam int unsigned N_IMAGES       = 12;
    localparam int unsigned IMGS_PER_CLASS = 4;
    localparam int unsigned TOTAL_PIXELS   = 784;
    localparam int unsigned CLS_BW         = 2;
    localparam int unsigned IMG_W          = 4;
    localparam int unsigned PASS_W         = 4;
    localparam int unsigned ERR_W          = 2;
    localparam int unsigned RES_TIMEOUT    = 4096;
    localparam int unsigned GAP_CYCLES     = 16;
    localparam int unsigned START_WINDOW   = 4;

    localparam int unsigned PIX_CNT_W = $clog2(TOTAL_PIXELS + 1);
    localparam int unsigned TMO_W     = $clog2(RES_TIMEOUT);
    localparam int unsigned GAP_W     = $clog2(GAP_CYCLES);

    // CNN class encoding.
    typedef enum logic [CLS_BW-1:0] {
        CLS_A = 2'd0,
        CLS_B = 2'd1,
        CLS_C = 2'd2
    } cls_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_STREAM,
        ST_WAIT_RES,
        ST_GAP,
        ST_DONE
    } state_e;

    // Images are stored class-major, IMGS_PER_CLASS variants per class.
    function automatic logic [CLS_BW-1:0] expected_class(input logic [IMG_W-1:0] idx);
        return CLS_BW'(idx / IMG_W'(IMGS_PER_CLASS));
    endfunction

endpackage

// File: rtl/fmap_frame_sequencer_frame_beat_counter.sv
// Counts valid beats of a stream and classifies the frame when valid falls.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   clear         synchronous clear of count and edge history
//   enable        count/detect only while high
//   beat          stream valid, one beat per high cycle
//   count         beats seen since clear (saturating)
//   complete_c    valid fell after exactly FRAME_LEN beats
//   short_c       valid fell after any other beat count
module fmap_frame_sequencer_frame_beat_counter
    import fmap_frame_sequencer_pkg::*;
#(
    parameter int unsigned FRAME_LEN = TOTAL_PIXELS
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             clear,
    input  logic                             enable,
    input  logic                             beat,
    output logic [$clog2(FRAME_LEN+1)-1:0]   count,
    output logic                             complete_c,
    output logic                             short_c
);

    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);

    logic beat_q;
    logic fall_c;

    assign fall_c     = enable && beat_q && !beat;
    assign complete_c = fall_c && (count == CNT_W'(FRAME_LEN));
    assign short_c    = fall_c && (count != CNT_W'(FRAME_LEN));

    // Beat count and one cycle of valid history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            beat_q <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            beat_q <= 1'b0;
        end else if (enable) begin
            beat_q <= beat;
            if (beat && count != '1) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fmap_frame_sequencer.sv
// Schedules frames from the fmap feeder into the CNN and scores the results.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   i_start            debounced start pulse
//   i_mode, i_sw       0 = single image i_sw, 1 = sweep all images
//   i_pix_valid        feeder output valid (observed only)
//   i_res_valid/class  CNN result strobe and class
//   o_img_sel          feeder image select, stable for a whole frame
//   o_feed_start       one-cycle feeder start pulse
//   o_busy, o_done     run in progress / end-of-run pulse
//   o_last_class       last accepted CNN class
//   o_pass_cnt         matching results in the current run
//   o_err              sticky: bit0 timeout, bit1 short frame / spurious result
module fmap_frame_sequencer
    import fmap_frame_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [IMG_W-1:0]  i_sw,
    input  logic              i_pix_valid,
    input  logic              i_res_valid,
    input  logic [CLS_BW-1:0] i_res_class,
    output logic [IMG_W-1:0]  o_img_sel,
    output logic              o_feed_start,
    output logic              o_busy,
    output logic              o_done,
    output logic [CLS_BW-1:0] o_last_class,
    output logic [PASS_W-1:0] o_pass_cnt,
    output logic [ERR_W-1:0]  o_err
);

    state_e                 state;
    logic                   mode_sweep;
    logic [IMG_W-1:0]       img_idx;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [PIX_CNT_W-1:0]   beat_cnt;
    logic                   complete_c;
    logic                   short_c;
    logic                   more_frames_c;

    assign more_frames_c = mode_sweep && (img_idx != IMG_W'(N_IMAGES - 1));

    fmap_frame_sequencer_frame_beat_counter #(
        .FRAME_LEN (TOTAL_PIXELS)
    ) u_beat_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (state == ST_KICK),
        .enable     (state == ST_STREAM),
        .beat       (i_pix_valid),
        .count      (beat_cnt),
        .complete_c (complete_c),
        .short_c    (short_c)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mode_sweep   <= 1'b0;
            img_idx      <= '0;
            tmo_cnt      <= '0;
            gap_cnt      <= '0;
            o_img_sel    <= '0;
            o_feed_start <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_last_class <= '0;
            o_pass_cnt   <= '0;
            o_err        <= '0;
        end else begin
            o_feed_start <= 1'b0;
            o_done       <= 1'b0;

            // A result strobe during a run but outside the result window is spurious.
            if (i_res_valid && state != ST_IDLE && state != ST_WAIT_RES) begin
                o_err[1] <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (!i_mode && i_sw >= IMG_W'(N_IMAGES)) begin
                            o_err[1] <= 1'b1;
                            o_done   <= 1'b1;
                        end else begin
                            mode_sweep <= i_mode;
                            img_idx    <= i_mode ? '0 : i_sw;
                            o_img_sel  <= i_mode ? '0 : i_sw;
                            o_pass_cnt <= '0;
                            o_err      <= '0;
                            o_busy     <= 1'b1;
                            state      <= ST_LOAD;
                        end
                    end
                end

                ST_LOAD: begin
                    o_feed_start <= 1'b1;
                    state        <= ST_KICK;
                end

                ST_KICK: begin
                    tmo_cnt <= '0;
                    state   <= ST_STREAM;
                end

                // tmo_cnt measures the start window here; it restarts for WAIT_RES.
                ST_STREAM: begin
                    if (complete_c || short_c) begin
                        if (short_c) begin
                            o_err[1] <= 1'b1;
                        end
                        tmo_cnt <= '0;
                        state   <= ST_WAIT_RES;
                    end else if (beat_cnt == '0 && !i_pix_valid &&
                                 tmo_cnt == TMO_W'(START_WINDOW - 1)) begin
                        o_err[1] <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= ST_WAIT_RES;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                // A result on the timeout cycle wins over the timeout.
                ST_WAIT_RES: begin
                    if (i_res_valid || tmo_cnt == TMO_W'(RES_TIMEOUT - 1)) begin
                        if (i_res_valid) begin
                            o_last_class <= i_res_class;
                            if (i_res_class == expected_class(img_idx) && o_pass_cnt != '1) begin
                                o_pass_cnt <= o_pass_cnt + PASS_W'(1);
                            end
                        end else begin
                            o_err[0] <= 1'b1;
                        end
                        if (more_frames_c) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            o_done <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        img_idx   <= img_idx + IMG_W'(1);
                        o_img_sel <= img_idx + IMG_W'(1);
                        state     <= ST_LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
